// File: rtl/rx_serial_8o1.sv
// ---------------------------------------------------------------------------
// rx_serial_8o1 -- asynchronous serial receiver, 8 data bits, odd parity,
// 1 stop bit (8O1), LSB first, idle-high line.
//
// The receiver looks for a falling edge on the line and confirms the start bit
// at half a bit period. It then samples every following bit in the middle of
// its period. The result is delivered through a level/acknowledge handshake:
// tem_dado stays high until limpa is seen.
//
// Parameters
//   BAUD_RATE       : 115200 selects M = 434 ticks per bit; any other value
//                     selects M = 5208 (9600 baud at 50 MHz).
//
// Ports
//   clock           : in   system clock (50 MHz)
//   reset           : in   synchronous, active-high reset
//   entrada_serial  : in   serial line, idle 1
//   limpa           : in   consumer acknowledge, clears tem_dado
//   dados_ascii     : out  [7:0] last received byte
//   tem_dado        : out  a byte is waiting to be consumed (level)
//   pronto          : out  one-cycle pulse when a frame completes
//   paridade_ok     : out  odd-parity check of the last frame
//   erro_frame      : out  stop bit of the last frame was sampled as 0
//   db_estado       : out  [6:0] FSM state code as seven-segment pattern
//                          (active-low, bit order g..a)
//   db_contagem     : out  [3:0] index of the bit being received
//   db_tick         : out  sampling tick
//
// Build option
//   RX_SERIAL_SYNC_EN : when defined, entrada_serial passes through a
//                       two-flop synchronizer. Both flops reset to 1. The
//                       synchronizer adds two cycles of latency.
// ---------------------------------------------------------------------------
module rx_serial_8o1 #(
    parameter int BAUD_RATE = 9600
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    input  logic       limpa,
    output logic [7:0] dados_ascii,
    output logic       tem_dado,
    output logic       pronto,
    output logic       paridade_ok,
    output logic       erro_frame,
    output logic [6:0] db_estado,
    output logic [3:0] db_contagem,
    output logic       db_tick
);

    localparam int M  = (BAUD_RATE == 115200) ? 434 : 5208;
    localparam int H  = M / 2;
    localparam int CW = $clog2(M);

    localparam logic [CW-1:0] M_LAST   = CW'(M - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        INICIAL      = 3'd0,
        CONFIRMA     = 3'd1,
        ESPERA       = 3'd2,
        AMOSTRA      = 3'd3,
        FIM          = 3'd4,
        AGUARDA_IDLE = 3'd5
    } state_t;

    // Seven-segment pattern (active-low, g..a) for one hex digit.
    function automatic logic [6:0] hexa7seg(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Odd parity holds when data bits plus parity bit have an odd count of ones.
    function automatic logic odd_parity_ok(input logic [8:0] data_and_parity);
        return ^data_and_parity;
    endfunction

    logic              linha_s;
    state_t            state_q;
    logic [CW-1:0]     tick_cnt_q;
    logic [3:0]        bit_cnt_q;
    logic [9:0]        shift_q;
    logic [7:0]        dados_q;
    logic              tem_dado_q;
    logic              pronto_q;
    logic              paridade_ok_q;
    logic              erro_frame_q;
    logic              db_tick_q;
    logic [6:0]        db_estado_q;

    logic [CW-1:0]     tick_cnt_d;
    logic [3:0]        bit_cnt_d;
    logic [9:0]        shift_d;

`ifdef RX_SERIAL_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    // Two-flop synchronizer. Reset to the idle level so no false start is seen.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= entrada_serial;
            sync2_q <= sync1_q;
        end
    end

    assign linha_s = sync2_q;
`else
    assign linha_s = entrada_serial;
`endif

    // Shifting right places d0 at bit 0 after ten samples; parity lands at
    // bit 8 and the stop bit at bit 9.
    assign tick_cnt_d = tick_cnt_q + CNT_ONE;
    assign bit_cnt_d  = bit_cnt_q + 4'd1;
    assign shift_d    = {linha_s, shift_q[9:1]};

    // Receiver FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= INICIAL;
            tick_cnt_q    <= CNT_ZERO;
            bit_cnt_q     <= 4'd0;
            shift_q       <= 10'd0;
            dados_q       <= 8'h00;
            tem_dado_q    <= 1'b0;
            pronto_q      <= 1'b0;
            paridade_ok_q <= 1'b0;
            erro_frame_q  <= 1'b0;
            db_tick_q     <= 1'b0;
        end else begin
            pronto_q  <= 1'b0;
            db_tick_q <= 1'b0;
            // The FIM branch below assigns tem_dado later in this block, so
            // completing a frame takes priority over an acknowledge.
            if (limpa) begin
                tem_dado_q <= 1'b0;
            end else begin
                tem_dado_q <= tem_dado_q;
            end

            case (state_q)
                INICIAL: begin
                    if (!linha_s) begin
                        tick_cnt_q <= CNT_ZERO;
                        bit_cnt_q  <= 4'd0;
                        state_q    <= CONFIRMA;
                    end else begin
                        state_q    <= INICIAL;
                    end
                end

                CONFIRMA: begin
                    if (tick_cnt_q == H_LAST) begin
                        tick_cnt_q <= CNT_ZERO;
                        if (linha_s) begin
                            state_q <= INICIAL;
                        end else begin
                            state_q <= ESPERA;
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_d;
                    end
                end

                ESPERA: begin
                    if (tick_cnt_q == M_LAST) begin
                        tick_cnt_q <= CNT_ZERO;
                        db_tick_q  <= 1'b1;
                        state_q    <= AMOSTRA;
                    end else begin
                        tick_cnt_q <= tick_cnt_d;
                    end
                end

                AMOSTRA: begin
                    // The counter keeps running through this cycle, so the
                    // sample spacing stays exactly M clocks.
                    tick_cnt_q <= tick_cnt_d;
                    shift_q    <= shift_d;
                    bit_cnt_q  <= bit_cnt_d;
                    if (bit_cnt_q == 4'd9) begin
                        state_q <= FIM;
                    end else begin
                        state_q <= ESPERA;
                    end
                end

                FIM: begin
                    dados_q       <= shift_q[7:0];
                    paridade_ok_q <= odd_parity_ok(shift_q[8:0]);
                    erro_frame_q  <= ~shift_q[9];
                    pronto_q      <= 1'b1;
                    tem_dado_q    <= 1'b1;
                    if (linha_s) begin
                        state_q <= INICIAL;
                    end else begin
                        state_q <= AGUARDA_IDLE;
                    end
                end

                AGUARDA_IDLE: begin
                    // A line held low (break) must not start a new frame.
                    if (linha_s) begin
                        state_q <= INICIAL;
                    end else begin
                        state_q <= AGUARDA_IDLE;
                    end
                end

                default: begin
                    state_q <= INICIAL;
                end
            endcase
        end
    end

    // Registered seven-segment view of the current state.
    always_ff @(posedge clock) begin
        if (reset) begin
            db_estado_q <= hexa7seg(4'd0);
        end else begin
            db_estado_q <= hexa7seg({1'b0, state_q});
        end
    end

    assign dados_ascii = dados_q;
    assign tem_dado    = tem_dado_q;
    assign pronto      = pronto_q;
    assign paridade_ok = paridade_ok_q;
    assign erro_frame  = erro_frame_q;
    assign db_estado   = db_estado_q;
    assign db_contagem = bit_cnt_q;
    assign db_tick     = db_tick_q;

endmodule

// File: tb/tb_rx_serial_8o1.sv
// ---------------------------------------------------------------------------
// Testbench for rx_serial_8o1 at 115200 baud (M = 434, H = 217).
// The stimulus task drives 8O1 frames cycle by cycle. Each frame that should
// complete pushes its expected byte and status flags into a queue. A monitor
// pops the queue and compares whenever pronto is high.
// ---------------------------------------------------------------------------
module tb_rx_serial_8o1;

    localparam int M = 434;
    localparam int H = 217;
    localparam int FRAME = 11 * M;
    localparam int PRONTO_EDGE = H + 10 * M + 2;

    localparam logic [6:0] SEG0 = 7'b1000000;
    localparam logic [6:0] SEG1 = 7'b1111001;
    localparam logic [6:0] SEG5 = 7'b0010010;

    typedef struct {
        logic [7:0] data;
        logic       pok;
        logic       ferr;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       line;
    logic       limpa;
    logic [7:0] dados_ascii;
    logic       tem_dado;
    logic       pronto;
    logic       paridade_ok;
    logic       erro_frame;
    logic [6:0] db_estado;
    logic [3:0] db_contagem;
    logic       db_tick;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic pronto_prev = 1'b0;

    rx_serial_8o1 #(.BAUD_RATE(115200)) dut (
        .clock          (clk),
        .reset          (reset),
        .entrada_serial (line),
        .limpa          (limpa),
        .dados_ascii    (dados_ascii),
        .tem_dado       (tem_dado),
        .pronto         (pronto),
        .paridade_ok    (paridade_ok),
        .erro_frame     (erro_frame),
        .db_estado      (db_estado),
        .db_contagem    (db_contagem),
        .db_tick        (db_tick)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: odd parity is fine when the ones in data plus the parity bit are odd.
    function automatic logic ref_parity_ok(input logic [7:0] d, input logic p);
        int ones;
        ones = $countones(d) + int'(p);
        return (ones % 2) == 1;
    endfunction

    // Monitor: each pronto pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (pronto) begin
            exp_t e;
            check("pronto_single_cycle", {31'd0, pronto_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pronto", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("dados_ascii", {24'd0, dados_ascii}, {24'd0, e.data});
                check("paridade_ok", {31'd0, paridade_ok}, {31'd0, e.pok});
                check("erro_frame",  {31'd0, erro_frame},  {31'd0, e.ferr});
                check("tem_dado_on_pronto", {31'd0, tem_dado}, 32'd1);
            end
        end
        pronto_prev <= pronto;
    end

    // Drive one frame. abort_at >= 0 pulses reset at that cycle and abandons
    // the frame. do_limpa runs the acknowledge-collision sequence around FIM.
    // break_hold keeps the line low after the stop bit for that many cycles.
    task automatic send_frame(input logic [7:0] data, input logic par, input logic stp,
                              input int abort_at, input logic do_limpa, input int break_hold);
        logic [9:0] bits;
        exp_t       e;
        bits = {stp, par, data};
        if (abort_at < 0) begin
            e.data = data;
            e.pok  = ref_parity_ok(data, par);
            e.ferr = ~stp;
            exp_q.push_back(e);
        end
        for (int c = 0; c < FRAME; c++) begin
            int idx;
            @(negedge clk);
            idx = c / M;
            line  = (idx == 0) ? 1'b0 : bits[idx-1];
            limpa = 1'b0;
            reset = 1'b0;
            if (abort_at >= 0 && c == abort_at + 1) break;
            if (c == abort_at) reset = 1'b1;
            if (do_limpa && c == PRONTO_EDGE) limpa = 1'b1;
            if (do_limpa && c == PRONTO_EDGE + 1) begin
                check("pronto_latency", {31'd0, pronto}, 32'd1);
                check("fim_wins_over_limpa", {31'd0, tem_dado}, 32'd1);
                limpa = 1'b1;
            end
            if (do_limpa && c == PRONTO_EDGE + 2) begin
                check("limpa_clears_tem_dado", {31'd0, tem_dado}, 32'd0);
            end
        end
        if (break_hold > 0) begin
            line = 1'b0;
            repeat (break_hold) @(negedge clk);
            check("break_holds_state5", {25'd0, db_estado}, {25'd0, SEG5});
            line = 1'b1;
            repeat (5) @(negedge clk);
            check("break_release_state0", {25'd0, db_estado}, {25'd0, SEG0});
        end
        @(negedge clk);
        line  = 1'b1;
        limpa = 1'b0;
        reset = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        logic [7:0] saved_data;
        logic       saved_tem;

        reset = 1'b1;
        line  = 1'b1;
        limpa = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dados",     {24'd0, dados_ascii}, 32'd0);
        check("rst_tem_dado",  {31'd0, tem_dado},    32'd0);
        check("rst_pronto",    {31'd0, pronto},      32'd0);
        check("rst_paridade",  {31'd0, paridade_ok}, 32'd0);
        check("rst_erro",      {31'd0, erro_frame},  32'd0);
        check("rst_contagem",  {28'd0, db_contagem}, 32'd0);
        check("rst_tick",      {31'd0, db_tick},     32'd0);
        check("rst_estado",    {25'd0, db_estado},   {25'd0, SEG0});
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Good parity, wrong parity, all ones.
        send_frame(8'h41, 1'b1, 1'b1, -1, 1'b0, 0);
        send_frame(8'h41, 1'b0, 1'b1, -1, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 1'b1, -1, 1'b0, 0);

        // Framing error followed by a break on the line.
        send_frame(8'h55, 1'b1, 1'b0, -1, 1'b0, 3 * M);

        // Short low glitch: a false start, with no output change.
        saved_data = dados_ascii;
        saved_tem  = tem_dado;
        @(negedge clk);
        line = 1'b0;
        repeat (50) @(negedge clk);
        check("glitch_in_confirma", {25'd0, db_estado}, {25'd0, SEG1});
        repeat (50) @(negedge clk);
        line = 1'b1;
        repeat (2 * H) @(negedge clk);
        check("glitch_state0",  {25'd0, db_estado},   {25'd0, SEG0});
        check("glitch_dados",   {24'd0, dados_ascii}, {24'd0, saved_data});
        check("glitch_tem",     {31'd0, tem_dado},    {31'd0, saved_tem});

        // Reset in the middle of bit 4 aborts the frame and clears the outputs.
        send_frame(8'h12, 1'b1, 1'b1, 5 * M + H, 1'b0, 0);
        check("abort_dados",    {24'd0, dados_ascii}, 32'd0);
        check("abort_tem",      {31'd0, tem_dado},    32'd0);
        check("abort_contagem", {28'd0, db_contagem}, 32'd0);
        check("abort_estado",   {25'd0, db_estado},   {25'd0, SEG0});
        send_frame(8'h30, 1'b1, 1'b1, -1, 1'b0, 0);

        // tem_dado is still 1 from 0x30; limpa collides with FIM of 0x7A.
        check("tem_before_collision", {31'd0, tem_dado}, 32'd1);
        send_frame(8'h7A, 1'b0, 1'b1, -1, 1'b1, 0);

        // Randomized frames, including an occasional framing error.
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            logic       p;
            logic       s;
            d = 8'($urandom_range(0, 255));
            p = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 3) != 0);
            send_frame(d, p, s, -1, 1'b0, 0);
        end

        repeat (10) @(negedge clk);
        check("all_frames_delivered", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
